counter_snapshot: RTL and testbench
===================================

COUNTER_SNAPSHOT -- requirements
Module: counter_snapshot

Interface
REQ-001 Parameter DEPTH, default 4, meaning FIFO entry count; power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 count_in  input  8  counter value, driven from counter_8bit data_out.
REQ-005 count_valid  input  1  count_in valid, driven from counter_8bit out_en.
REQ-006 trig  input  1  capture request; acts on its rising edge.
REQ-007 snap_ready  input  1  consumer accepts head entry this cycle.
REQ-008 clr_ovf  input  1  clears sticky overflow flag.
REQ-009 snap_data  output  8  head FIFO entry (first-word fall-through).
REQ-010 snap_valid  output  1  snap_data holds a valid entry.
REQ-011 level  output  clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-012 full  output  1  level == DEPTH.
REQ-013 empty  output  1  level == 0.
REQ-014 overflow  output  1  sticky: a capture was dropped.

Function
REQ-015 The block SHALL register trig into trig_d every cycle; a trigger event SHALL be trig=1 and trig_d=0.
REQ-016 A capture SHALL be requested on a trigger event with count_valid=1; a trigger event with count_valid=0 SHALL be ignored, with no write and no overflow.
REQ-017 A pop SHALL occur when snap_valid=1 and snap_ready=1; snap_ready with snap_valid=0 SHALL have no effect.
REQ-018 A capture SHALL write count_in at the write pointer when full=0, or when full=1 and a pop occurs in the same cycle.
REQ-019 A capture with full=1 and no pop SHALL be dropped and SHALL set overflow to 1.
REQ-020 Latency: a capture at edge N SHALL make the entry visible on snap_data, with snap_valid=1, after edge N, provided the FIFO was empty.
REQ-021 snap_valid SHALL equal not empty, and snap_data SHALL equal the head entry when valid and 8'h00 when empty.
REQ-022 Entries SHALL be output in capture order, and read and write pointers SHALL wrap modulo DEPTH.
REQ-023 Level SHALL change as follows: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop, never beyond 0..DEPTH.
REQ-024 Simultaneous write and pop when empty is impossible, because a pop requires snap_valid; the new entry SHALL appear next cycle.
REQ-025 clr_ovf=1 SHALL clear overflow, except that an overflow event in the same cycle SHALL win and leave overflow at 1.
REQ-026 full, empty and level SHALL be registered or derived only from registered state, with no combinational path from inputs.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set pointers=0, level=0, trig_d=0 and overflow=0, giving empty=1, full=0, snap_valid=0 and snap_data=8'h00.
REQ-028 Reset SHALL take priority over capture, pop and clr_ovf in the same cycle.
REQ-029 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-030 If trig is held at 1 across reset release, the first cycle after reset SHALL see a trigger event (trig_d=0).

Verification
REQ-031 Scenario: reset, then count_valid=1, count_in=8'h2A, pulse trig once -> the next cycle shows snap_valid=1, snap_data=8'h2A, level=1; snap_ready=1 for 1 cycle -> empty=1, snap_data=8'h00.
REQ-032 Scenario: hold trig=1 for 5 cycles with count_valid=1 -> exactly 1 entry is captured.
REQ-033 Scenario: DEPTH=4, capture 8'h01..8'h05 with snap_ready=0 -> full=1, level=4, overflow=1; drain -> 01,02,03,04 in order, with 05 absent.
REQ-034 Scenario: FIFO full, capture and pop in the same cycle -> level stays 4, the new value is last out, overflow stays 0.
REQ-035 Scenario: overflow=1, clr_ovf=1 with no drop -> overflow=0; clr_ovf=1 together with a dropped capture -> overflow=1.
REQ-036 Scenario: 3 entries stored, rst=1 for 1 cycle with trig edge and snap_ready asserted -> level=0, snap_valid=0, overflow=0, with no capture.

Source files
------------

// File: rtl/counter_snapshot.sv
// Snapshot FIFO for an 8-bit free-running counter: each rising edge of trig
// captures count_in into a first-word fall-through FIFO with sticky overflow.
module counter_snapshot #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               count_in,
    input  logic                     count_valid,
    input  logic                     trig,
    input  logic                     snap_ready,
    input  logic                     clr_ovf,
    output logic [7:0]               snap_data,
    output logic                     snap_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [LW-1:0] r_level;
    logic          r_trigD;
    logic          r_overflow;

    logic w_empty;
    logic w_full;
    logic w_trigEvent;
    logic w_capture;
    logic w_pop;
    logic w_write;
    logic w_drop;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == FULL_LEVEL);
    assign w_trigEvent = trig & ~r_trigD;
    assign w_capture   = w_trigEvent & count_valid;
    assign w_pop       = ~w_empty & snap_ready;
    // A pop frees the slot the write needs, so a full FIFO still accepts it.
    assign w_write     = w_capture & (~w_full | w_pop);
    assign w_drop      = w_capture & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trigD    <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_trigD <= trig;
            if (w_write)
                r_wrPtr <= r_wrPtr + PW'(1);
            if (w_pop)
                r_rdPtr <= r_rdPtr + PW'(1);
            if (w_write && !w_pop)
                r_level <= r_level + LW'(1);
            else if (!w_write && w_pop)
                r_level <= r_level - LW'(1);
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_ovf)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_write)
            r_mem[r_wrPtr] <= count_in;
    end

    assign snap_valid = ~w_empty;
    assign snap_data  = w_empty ? 8'h00 : r_mem[r_rdPtr];
    assign level      = r_level;
    assign full       = w_full;
    assign empty      = w_empty;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_counter_snapshot.sv
// Directed self-checking bench for counter_snapshot (DEPTH = 4); every check is
// an immediate assertion against a hand-computed value.
module tb_counter_snapshot;

    logic       clk;
    logic       rst;
    logic [7:0] count_in;
    logic       count_valid;
    logic       trig;
    logic       snap_ready;
    logic       clr_ovf;
    logic [7:0] snap_data;
    logic       snap_valid;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;

    int checkCount = 0;
    int failCount  = 0;

    counter_snapshot #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .count_valid(count_valid),
        .trig       (trig),
        .snap_ready (snap_ready),
        .clr_ovf    (clr_ovf),
        .snap_data  (snap_data),
        .snap_valid (snap_valid),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 ns after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // One trigger pulse followed by a low cycle to re-arm edge detection.
    task automatic captureOne(input logic [7:0] value);
        count_in    = value;
        count_valid = 1'b1;
        trig        = 1'b1;
        applyStimulus();
        trig = 1'b0;
        applyStimulus();
    endtask

    initial begin
        rst         = 1'b1;
        count_in    = 8'h00;
        count_valid = 1'b0;
        trig        = 1'b0;
        snap_ready  = 1'b0;
        clr_ovf     = 1'b0;
        #2;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;

        checkOutput("reset_empty",    {7'd0, empty},      8'h01);
        checkOutput("reset_full",     {7'd0, full},       8'h00);
        checkOutput("reset_valid",    {7'd0, snap_valid}, 8'h00);
        checkOutput("reset_data",     snap_data,          8'h00);
        checkOutput("reset_level",    {5'd0, level},      8'h00);
        checkOutput("reset_overflow", {7'd0, overflow},   8'h00);

        // Single capture is visible right after its edge, then popped.
        count_in    = 8'h2A;
        count_valid = 1'b1;
        trig        = 1'b1;
        applyStimulus();
        trig = 1'b0;
        checkOutput("single_valid", {7'd0, snap_valid}, 8'h01);
        checkOutput("single_data",  snap_data,          8'h2A);
        checkOutput("single_level", {5'd0, level},      8'h01);
        snap_ready = 1'b1;
        applyStimulus();
        snap_ready = 1'b0;
        checkOutput("single_pop_empty", {7'd0, empty}, 8'h01);
        checkOutput("single_pop_data",  snap_data,     8'h00);

        // Trig held high for five cycles yields exactly one capture.
        trig = 1'b1;
        for (int i = 0; i < 5; i++) begin
            count_in = 8'h10 + 8'(i);
            applyStimulus();
        end
        trig = 1'b0;
        checkOutput("held_level", {5'd0, level}, 8'h01);
        checkOutput("held_data",  snap_data,     8'h10);
        snap_ready = 1'b1;
        applyStimulus();
        snap_ready = 1'b0;
        applyStimulus();

        // Trigger with count_valid low is ignored.
        count_valid = 1'b0;
        trig        = 1'b1;
        applyStimulus();
        trig = 1'b0;
        applyStimulus();
        checkOutput("invalid_level",    {5'd0, level},    8'h00);
        checkOutput("invalid_overflow", {7'd0, overflow}, 8'h00);

        // Fill to four, fifth capture is dropped and sets overflow.
        for (int i = 1; i <= 4; i++) captureOne(8'(i));
        checkOutput("fill_full",     {7'd0, full},     8'h01);
        checkOutput("fill_level",    {5'd0, level},    8'h04);
        checkOutput("fill_overflow", {7'd0, overflow}, 8'h00);
        captureOne(8'h05);
        checkOutput("drop_level",    {5'd0, level},    8'h04);
        checkOutput("drop_overflow", {7'd0, overflow}, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_order", snap_data, 8'(i));
            snap_ready = 1'b1;
            applyStimulus();
        end
        checkOutput("drain_empty", {7'd0, empty}, 8'h01);
        applyStimulus();
        snap_ready = 1'b0;
        checkOutput("ready_when_empty_level", {5'd0, level}, 8'h00);

        // Clearing overflow with no drop.
        clr_ovf = 1'b1;
        applyStimulus();
        clr_ovf = 1'b0;
        checkOutput("clr_overflow", {7'd0, overflow}, 8'h00);

        // Full FIFO with simultaneous capture and pop keeps level at four.
        for (int i = 0; i < 4; i++) captureOne(8'hA0 + 8'(i));
        checkOutput("swap_head_before", snap_data, 8'hA0);
        count_in    = 8'hA4;
        count_valid = 1'b1;
        trig        = 1'b1;
        snap_ready  = 1'b1;
        applyStimulus();
        trig       = 1'b0;
        snap_ready = 1'b0;
        checkOutput("swap_level",    {5'd0, level},    8'h04);
        checkOutput("swap_overflow", {7'd0, overflow}, 8'h00);
        checkOutput("swap_head",     snap_data,        8'hA1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("swap_order", snap_data, 8'hA0 + 8'(i));
            snap_ready = 1'b1;
            applyStimulus();
        end
        snap_ready = 1'b0;
        checkOutput("swap_drain_empty", {7'd0, empty}, 8'h01);

        // Drop in the same cycle as clr_ovf keeps overflow set.
        for (int i = 0; i < 4; i++) captureOne(8'hB0 + 8'(i));
        count_in = 8'hB5;
        trig     = 1'b1;
        clr_ovf  = 1'b1;
        applyStimulus();
        trig = 1'b0;
        checkOutput("clr_vs_drop", {7'd0, overflow}, 8'h01);
        applyStimulus();
        clr_ovf = 1'b0;
        checkOutput("clr_after_drop", {7'd0, overflow}, 8'h00);
        checkOutput("clr_level_kept", {5'd0, level},    8'h04);

        // Reset with three stored entries, trig edge and ready all asserted.
        snap_ready = 1'b1;
        applyStimulus();
        snap_ready = 1'b0;
        checkOutput("pre_reset_level", {5'd0, level}, 8'h03);
        rst         = 1'b1;
        count_in    = 8'hC7;
        count_valid = 1'b1;
        trig        = 1'b1;
        snap_ready  = 1'b1;
        applyStimulus();
        snap_ready = 1'b0;
        checkOutput("mid_reset_level",    {5'd0, level},      8'h00);
        checkOutput("mid_reset_valid",    {7'd0, snap_valid}, 8'h00);
        checkOutput("mid_reset_overflow", {7'd0, overflow},   8'h00);
        checkOutput("mid_reset_data",     snap_data,          8'h00);

        // Trig held across reset release is seen as a fresh edge.
        rst = 1'b0;
        applyStimulus();
        trig = 1'b0;
        checkOutput("post_reset_level", {5'd0, level}, 8'h01);
        checkOutput("post_reset_data",  snap_data,     8'hC7);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
